// File: rtl/bp_trace_arbiter_pkg.sv
// Shared types for the trace arbiter: Nexus packet layout, message codes, run-control states.
// Source ID is not carried in the packet; it travels on a separate sideband.
package bp_trace_arbiter_pkg;

  localparam logic [5:0] NEXUS_MCODE_OWNERSHIP = 6'd2;
  localparam logic [5:0] NEXUS_MCODE_DIRECT_BR = 6'd3;
  localparam logic [5:0] NEXUS_MCODE_INDIR_BR  = 6'd4;
  localparam logic [5:0] NEXUS_MCODE_SYNC      = 6'd9;

  typedef struct packed {
    logic [5:0]  mcode;
    logic [63:0] addr;
    logic [15:0] icnt;
  } nexus_trace_pkt_s;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } bp_trace_arb_state_e;

  // Increment an index modulo n.
  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bp_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins.
module bp_rr_arbiter
  import bp_trace_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [SRC_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [SRC_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  always_comb begin
    int unsigned idx;
    logic        found;
    idx         = 0;
    found       = 1'b0;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      idx = (32'(ptr_i) + i) % NUM_SRC;
      if (!found && req_i[SRC_W'(idx)]) begin
        found                = 1'b1;
        gnt_o[SRC_W'(idx)]   = 1'b1;
        gnt_idx_o            = SRC_W'(idx);
        gnt_valid_o          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_trace_arbiter.sv
// Shares one Nexus trace port between NUM_SRC encoders: round-robin grant into a
// single-entry output register, start/stop FSM with clean drain, per-source packet counters.
module bp_trace_arbiter
  import bp_trace_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned SRC_W   = $clog2(NUM_SRC),
  parameter int unsigned CNT_W   = 16
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            enable_i,
  input  logic                            clear_cnt_i,
  input  nexus_trace_pkt_s [NUM_SRC-1:0]  src_pkt_i,
  input  logic [NUM_SRC-1:0]              src_valid_i,
  output logic [NUM_SRC-1:0]              src_ready_o,
  output nexus_trace_pkt_s                trace_pkt_o,
  output logic [SRC_W-1:0]                trace_src_o,
  output logic                            trace_valid_o,
  input  logic                            trace_ready_i,
  output logic [1:0]                      state_o,
  output logic [NUM_SRC-1:0][CNT_W-1:0]   pkt_cnt_o
);

  bp_trace_arb_state_e state_q, state_d;

  nexus_trace_pkt_s pkt_q, pkt_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic             valid_q, valid_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;

  logic [NUM_SRC-1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_SRC-1:0] arb_gnt;
  logic [SRC_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               run;
  logic               load_ok;
  logic               grant;

  bp_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_rr_arbiter (
    .req_i       (src_valid_i),
    .ptr_i       (ptr_q),
    .gnt_o       (arb_gnt),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  // FSM: state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable_i) state_d = StRun;
      StRun:   if (!enable_i) state_d = StDrain;
      // Drain always finishes to idle, even if enable comes back.
      StDrain: if (!valid_q || trace_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    state_o = state_q;
    run     = (state_q == StRun);
  end

  assign load_ok     = !valid_q || trace_ready_i;
  assign grant       = run && enable_i && load_ok && arb_valid;
  assign src_ready_o = grant ? arb_gnt : '0;

  always_comb begin
    pkt_d   = pkt_q;
    src_d   = src_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (grant) begin
      pkt_d   = src_pkt_i[arb_idx];
      src_d   = arb_idx;
      valid_d = 1'b1;
      ptr_d   = SRC_W'(wrap_inc(32'(arb_idx), NUM_SRC));
    end else if (trace_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_cnt_i) begin
        cnt_d[i] = '0;
      end else if (src_valid_i[i] && src_ready_o[i] && !(&cnt_q[i])) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pkt_q   <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pkt_q   <= pkt_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign trace_pkt_o   = pkt_q;
  assign trace_src_o   = src_q;
  assign trace_valid_o = valid_q;
  assign pkt_cnt_o     = cnt_q;

endmodule

// File: tb/tb_bp_trace_arbiter.sv
// Directed bench for bp_trace_arbiter (2 sources, 4-bit counters so saturation is reachable).
module tb_bp_trace_arbiter;
  import bp_trace_arbiter_pkg::*;

  logic                   clk;
  logic                   reset_n;
  logic                   enable;
  logic                   clear_cnt;
  nexus_trace_pkt_s [1:0] src_pkt;
  logic [1:0]             src_valid;
  logic [1:0]             src_ready;
  nexus_trace_pkt_s       trace_pkt;
  logic                   trace_src;
  logic                   trace_valid;
  logic                   trace_ready;
  logic [1:0]             state;
  logic [1:0][3:0]        pkt_cnt;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  bp_trace_arbiter #(
    .NUM_SRC (2),
    .CNT_W   (4)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .enable_i      (enable),
    .clear_cnt_i   (clear_cnt),
    .src_pkt_i     (src_pkt),
    .src_valid_i   (src_valid),
    .src_ready_o   (src_ready),
    .trace_pkt_o   (trace_pkt),
    .trace_src_o   (trace_src),
    .trace_valid_o (trace_valid),
    .trace_ready_i (trace_ready),
    .state_o       (state),
    .pkt_cnt_o     (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic nexus_trace_pkt_s mk(logic [63:0] addr);
    nexus_trace_pkt_s p;
    p.mcode = NEXUS_MCODE_DIRECT_BR;
    p.addr  = addr;
    p.icnt  = addr[15:0] ^ 16'h5a5a;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b0;
    clear_cnt   = 1'b0;
    src_pkt[0]  = '0;
    src_pkt[1]  = '0;
    src_valid   = 2'b00;
    trace_ready = 1'b0;
    #2;
    chk("rst_state", 64'(state), 64'(StIdle));
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_pkt_addr", trace_pkt.addr, 64'd0);
    chk("rst_src", 64'(trace_src), 64'd0);
    chk("rst_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_ready", 64'(src_ready), 64'd0);
    #6 reset_n = 1'b1;

    // Single source
    cyc();
    enable = 1'b1; src_valid = 2'b01; src_pkt[0] = mk(64'h1000); trace_ready = 1'b1;
    #1;
    chk("single_idle_state", 64'(state), 64'(StIdle));
    chk("single_idle_ready", 64'(src_ready), 64'd0);
    cyc(); #1;
    chk("single_run_state", 64'(state), 64'(StRun));
    chk("single_grant", 64'(src_ready), 64'b01);
    cyc();
    src_valid = 2'b00;
    #1;
    chk("single_valid", 64'(trace_valid), 64'd1);
    chk("single_addr", trace_pkt.addr, 64'h1000);
    chk("single_src", 64'(trace_src), 64'd0);
    chk("single_cnt0", 64'(pkt_cnt[0]), 64'd1);
    chk("single_noready", 64'(src_ready), 64'd0);
    cyc();
    clear_cnt = 1'b1;
    #1;
    chk("single_drained", 64'(trace_valid), 64'd0);

    // Contention: pointer sits at 1 after the single grant to src0
    cyc();
    clear_cnt = 1'b0; src_valid = 2'b11;
    src_pkt[0] = mk(64'hA0); src_pkt[1] = mk(64'hA1);
    #1;
    chk("clear_cnt0", 64'(pkt_cnt[0]), 64'd0);
    chk("cont_gnt0", 64'(src_ready), 64'b10);
    cyc(); #1;
    chk("cont_src0", 64'(trace_src), 64'd1);
    chk("cont_addr0", trace_pkt.addr, 64'hA1);
    chk("cont_gnt1", 64'(src_ready), 64'b01);
    cyc(); #1;
    chk("cont_src1", 64'(trace_src), 64'd0);
    chk("cont_gnt2", 64'(src_ready), 64'b10);
    cyc(); #1;
    chk("cont_src2", 64'(trace_src), 64'd1);
    chk("cont_gnt3", 64'(src_ready), 64'b01);
    cyc();
    src_valid = 2'b01; src_pkt[0] = mk(64'hFFFF_FFFF_8000_0000);
    #1;
    chk("cont_src3", 64'(trace_src), 64'd0);
    chk("cont_valid", 64'(trace_valid), 64'd1);
    chk("cont_cnt0", 64'(pkt_cnt[0]), 64'd2);
    chk("cont_cnt1", 64'(pkt_cnt[1]), 64'd2);
    chk("bp_load_gnt", 64'(src_ready), 64'b01);

    // Backpressure
    cyc();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", 64'(trace_valid), 64'd1);
      chk("bp_addr", trace_pkt.addr, 64'hFFFF_FFFF_8000_0000);
      chk("bp_src", 64'(trace_src), 64'd0);
      chk("bp_noready", 64'(src_ready), 64'd0);
      chk("bp_cnt0", 64'(pkt_cnt[0]), 64'd3);
      cyc();
    end
    trace_ready = 1'b1;
    #1;
    chk("bp_resume_gnt", 64'(src_ready), 64'b01);
    cyc();
    src_valid = 2'b00;
    #1;
    chk("bp_resume_valid", 64'(trace_valid), 64'd1);
    chk("bp_resume_cnt0", 64'(pkt_cnt[0]), 64'd4);

    // Disable mid-stream
    cyc();
    src_valid = 2'b01; src_pkt[0] = mk(64'h2000);
    #1;
    chk("dis_load_gnt", 64'(src_ready), 64'b01);
    cyc();
    src_valid = 2'b00; trace_ready = 1'b0; enable = 1'b0;
    #1;
    chk("dis_gated", 64'(src_ready), 64'd0);
    chk("dis_full", 64'(trace_valid), 64'd1);
    chk("dis_addr", trace_pkt.addr, 64'h2000);
    cyc();
    src_valid = 2'b01; enable = 1'b1;
    #1;
    chk("drain_state", 64'(state), 64'(StDrain));
    chk("drain_nogrant", 64'(src_ready), 64'd0);
    chk("drain_held", 64'(trace_valid), 64'd1);
    cyc();
    trace_ready = 1'b1;
    #1;
    chk("drain_state2", 64'(state), 64'(StDrain));
    chk("drain_nogrant2", 64'(src_ready), 64'd0);
    cyc(); #1;
    chk("drain_idle", 64'(state), 64'(StIdle));
    chk("drain_empty", 64'(trace_valid), 64'd0);
    chk("drain_idle_noready", 64'(src_ready), 64'd0);
    cyc();
    clear_cnt = 1'b1;
    #1;
    chk("rerun_state", 64'(state), 64'(StRun));
    chk("rerun_gnt", 64'(src_ready), 64'b01);
    chk("rerun_cnt0", 64'(pkt_cnt[0]), 64'd5);

    // Clear beats a simultaneous accept, then saturate
    cyc();
    clear_cnt = 1'b0;
    #1;
    chk("clr_win_cnt0", 64'(pkt_cnt[0]), 64'd0);
    chk("clr_win_cnt1", 64'(pkt_cnt[1]), 64'd0);
    for (int i = 0; i < 20; i++) cyc();
    #1;
    chk("sat_cnt0", 64'(pkt_cnt[0]), 64'd15);
    chk("sat_cnt1", 64'(pkt_cnt[1]), 64'd0);
    chk("sat_gnt", 64'(src_ready), 64'b01);
    clear_cnt = 1'b1;
    cyc();
    clear_cnt = 1'b0;
    #1;
    chk("sat_clear", 64'(pkt_cnt[0]), 64'd0);
    chk("stream_valid", 64'(trace_valid), 64'd1);
    cyc(); #1;
    chk("post_clear_cnt0", 64'(pkt_cnt[0]), 64'd1);

    // Async reset between edges with a packet in the output register
    #1 reset_n = 1'b0;
    #1;
    chk("arst_state", 64'(state), 64'(StIdle));
    chk("arst_valid", 64'(trace_valid), 64'd0);
    chk("arst_addr", trace_pkt.addr, 64'd0);
    chk("arst_src", 64'(trace_src), 64'd0);
    chk("arst_cnt", 64'(pkt_cnt), 64'd0);
    chk("arst_ready", 64'(src_ready), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bp_trace_arbiter.md
# bp_trace_arbiter

Round-robin arbiter and run-control sequencer that shares one Nexus trace output port between `NUM_SRC` instances of `bp_trace_encoder`, one encoder per core/hart. Sits between the per-core encoders' `trace_pkt_o/trace_valid_o/trace_ready_i` ports and the single downstream trace sink (FIFO/funnel). Provides a registered output stage and a trace start/stop FSM with clean drain. Keeps saturating per-source packet counters for debug.

## Interface
- `NUM_SRC`, default 2: number of encoder sources, ≥2.
- `SRC_W`, default `$clog2(NUM_SRC)`: source-ID width; derived, do not override.
- `CNT_W`, default 16: per-source packet counter width.

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `enable_i` in 1: trace enable from control CSR.
- `clear_cnt_i` in 1: synchronous clear of all packet counters.
- `src_pkt_i` in `NUM_SRC` x `nexus_trace_pkt_s`: per-source packet.
- `src_valid_i` in `NUM_SRC`: per-source valid.
- `src_ready_o` out `NUM_SRC`: per-source ready, one-hot or zero.
- `trace_pkt_o` out `nexus_trace_pkt_s`: granted packet, registered.
- `trace_src_o` out `SRC_W`: source index of `trace_pkt_o`.
- `trace_valid_o` out 1: output valid.
- `trace_ready_i` in 1: sink ready.
- `state_o` out 2: FSM state, IDLE=0, RUN=1, DRAIN=2.
- `pkt_cnt_o` out `NUM_SRC` x `CNT_W`: packets accepted per source.

## Operation
FSM states and transitions:
- IDLE: no grants; `src_ready_o`=0. `enable_i`=1 → RUN next cycle.
- RUN: arbitrate. `enable_i`=0 → DRAIN next cycle. Grants are gated combinationally by `enable_i`, so no grant occurs in the cycle `enable_i` is low.
- DRAIN: no grants. Go to IDLE when the output register is empty, or is emptying this cycle (`trace_valid_o & trace_ready_i`). DRAIN always completes to IDLE, even if `enable_i` re-asserts; RUN is re-entered from IDLE.

Output register:
- Single-entry register. Loadable when empty or dequeuing this cycle (`load_ok = !trace_valid_o | trace_ready_i`).
- Grant happens only in RUN with `enable_i` & `load_ok` & any `src_valid_i`.
- On grant g: `src_ready_o[g]`=1. Next edge loads `trace_pkt_o<=src_pkt_i[g]`, `trace_src_o<=g`, `trace_valid_o<=1`.
- Dequeue with no new grant clears `trace_valid_o`.
- While `trace_valid_o & !trace_ready_i`, `trace_pkt_o`/`trace_src_o` hold stable.

Arbitration:
- Round-robin pointer `ptr` (`SRC_W` bits, reset 0). Grant = first valid index scanning `ptr, ptr+1, …` mod `NUM_SRC`.
- On grant, `ptr <= (g+1) mod NUM_SRC`. No grant leaves `ptr` unchanged.
- `src_ready_o` depends combinationally on `src_valid_i`. Sources must not derive valid from ready (encoder complies).

Packet counters:
- `pkt_cnt_o[i]` increments on `src_valid_i[i] & src_ready_o[i]`, saturating at all-ones.
- `clear_cnt_i` zeroes all counters. Clear wins over a simultaneous increment.

## Timing
- Latency from source handshake to `trace_valid_o` is 1 cycle. Throughput is 1 packet/cycle under continuous `trace_ready_i`.
- Reset values: `state_o`=IDLE, `trace_valid_o`=0, `trace_pkt_o`='0, `trace_src_o`=0, `pkt_cnt_o`=0, `ptr`=0. `src_ready_o`=0, combinational from IDLE.
- Asserting reset mid-operation clears all state immediately; an unsent packet in the output register is discarded.
- First possible grant is 1 cycle after `enable_i` rises in IDLE (IDLE→RUN edge), giving first `trace_valid_o` 2 cycles after `enable_i`.
- Simultaneous dequeue and grant: register reloads, and `trace_valid_o` stays 1 with no bubble.
- `enable_i` falling while `trace_valid_o & !trace_ready_i`: stay in DRAIN until the sink accepts.

## Structure
- `nexus_trace_pkt_s` and the `NEXUS_MCODE_*` constants stay in `bp_nexus_defines.svh`. This block adds no fields to the packet; source ID travels on `trace_src_o`.
- Add FSM state enum `bp_trace_arb_state_e` (IDLE/RUN/DRAIN) to the same shared defines for `state_o` decoding by CSR/bench.
- One sub-module: `bp_rr_arbiter` (parameterised `NUM_SRC`, request vector + pointer in, one-hot grant + grant index out, combinational).

## Test plan
- Single source: enable, src0 valid with addr=64'h1000, ready=1 → `trace_valid_o` 2 cycles after enable, `trace_src_o`=0, `pkt_cnt_o[0]`=1.
- Contention: src0 and src1 valid every cycle, ready=1 → `trace_src_o` sequence 0,1,0,1,…; counters equal ±1.
- Backpressure: `trace_ready_i`=0 for 5 cycles with packet addr=64'hFFFF_FFFF_8000_0000 held → output stable; `src_ready_o`=0; no counter change; resumes on ready.
- Disable mid-stream: drop `enable_i` with output full and ready=0 → `state_o`=DRAIN, no grants; after ready=1 → packet delivered, then IDLE.
- Counter saturation (`CNT_W`=4): 20 accepted src0 packets → `pkt_cnt_o[0]`=15. Then `clear_cnt_i` with a simultaneous accept → 0.
- Async reset: assert `reset_n_i` between edges with `trace_valid_o`=1 → all outputs at reset values before the next edge.
